// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver: sequential initiator for a combinational 32-bit AND/OR/ADD/SUB ALU.
// Accepts commands over valid/ready and drives the operands and decoded controls onto the ALU.
// It then waits SETTLE_CYCLES for the ripple adder to settle and captures Result/CarryOut.
// The captured result and flags are returned over a valid/ready response channel.
// SLT is derived from the subtract result and its signed overflow.
// Optional build macro ALU_DRV_OVF_EN adds the rsp_ovf signed-overflow output.
module alu_cmd_driver #(
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_binvert,
    output logic             alu_carryin,
    output logic [1:0]       alu_operation,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carryout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_carry,
    output logic             rsp_err
`ifdef ALU_DRV_OVF_EN
    ,
    output logic             rsp_ovf
`endif
);

    localparam int MSB = WIDTH - 1;
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t           state_reg;
    logic [3:0]       count_reg;
    logic [2:0]       op_reg;
    logic             cmd_ready_reg;
    logic [WIDTH-1:0] alu_a_reg;
    logic [WIDTH-1:0] alu_b_reg;
    logic             binvert_reg;
    logic [1:0]       operation_reg;
    logic             rsp_valid_reg;
    logic [WIDTH-1:0] rsp_result_reg;
    logic             rsp_zero_reg;
    logic             rsp_carry_reg;
    logic             rsp_err_reg;

    logic             dec_legal;
    logic             dec_binvert;
    logic [1:0]       dec_operation;
    logic             ovf_sub;
    logic [WIDTH-1:0] result_next;
    logic             carry_next;

    // Opcode decode into ALU control lines; SLT reuses the subtract datapath
    always_comb begin
        dec_legal     = 1'b1;
        dec_binvert   = 1'b0;
        dec_operation = 2'b10;
        case (cmd_op)
            OP_AND:  dec_operation = 2'b00;
            OP_OR:   dec_operation = 2'b01;
            OP_ADD:  dec_operation = 2'b10;
            OP_SUB,
            OP_SLT:  dec_binvert   = 1'b1;
            default: dec_legal     = 1'b0;
        endcase
    end

    // Result and carry to capture from the settled ALU, shaped by the registered op
    always_comb begin
        ovf_sub     = (alu_a_reg[MSB] != alu_b_reg[MSB]) && (alu_result[MSB] != alu_a_reg[MSB]);
        result_next = alu_result;
        carry_next  = 1'b0;
        case (op_reg)
            OP_ADD,
            OP_SUB: carry_next = alu_carryout;
            OP_SLT: begin
                result_next    = '0;
                result_next[0] = alu_result[MSB] ^ ovf_sub;
            end
            default: carry_next = 1'b0;
        endcase
    end

`ifdef ALU_DRV_OVF_EN
    logic rsp_ovf_reg;
    logic ovf_next;

    // Signed overflow for ADD/SUB; ADD compares against the uninverted operand B
    always_comb begin
        ovf_next = 1'b0;
        if (op_reg == OP_ADD)
            ovf_next = (alu_a_reg[MSB] == alu_b_reg[MSB]) && (alu_result[MSB] != alu_a_reg[MSB]);
        else if (op_reg == OP_SUB)
            ovf_next = ovf_sub;
    end

    assign rsp_ovf = rsp_ovf_reg;
`endif

    // Command/execute/response sequencer with all outputs registered
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            count_reg      <= '0;
            op_reg         <= '0;
            cmd_ready_reg  <= 1'b1;
            alu_a_reg      <= '0;
            alu_b_reg      <= '0;
            binvert_reg    <= 1'b0;
            operation_reg  <= '0;
            rsp_valid_reg  <= 1'b0;
            rsp_result_reg <= '0;
            rsp_zero_reg   <= 1'b0;
            rsp_carry_reg  <= 1'b0;
            rsp_err_reg    <= 1'b0;
`ifdef ALU_DRV_OVF_EN
            rsp_ovf_reg    <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cmd_valid && cmd_ready_reg) begin
                        op_reg        <= cmd_op;
                        cmd_ready_reg <= 1'b0;
                        if (dec_legal) begin
                            alu_a_reg     <= cmd_a;
                            alu_b_reg     <= cmd_b;
                            binvert_reg   <= dec_binvert;
                            operation_reg <= dec_operation;
                            count_reg     <= SETTLE_LOAD;
                            state_reg     <= EXEC;
                        end else begin
                            // Illegal ops bypass the ALU and answer immediately
                            rsp_result_reg <= '0;
                            rsp_err_reg    <= 1'b1;
                            rsp_zero_reg   <= 1'b1;
                            rsp_carry_reg  <= 1'b0;
`ifdef ALU_DRV_OVF_EN
                            rsp_ovf_reg    <= 1'b0;
`endif
                            rsp_valid_reg  <= 1'b1;
                            state_reg      <= DONE;
                        end
                    end
                end
                EXEC: begin
                    count_reg <= count_reg - 4'd1;
                    if (count_reg == 4'd1) begin
                        rsp_result_reg <= result_next;
                        rsp_zero_reg   <= (result_next == '0);
                        rsp_carry_reg  <= carry_next;
                        rsp_err_reg    <= 1'b0;
`ifdef ALU_DRV_OVF_EN
                        rsp_ovf_reg    <= ovf_next;
`endif
                        rsp_valid_reg  <= 1'b1;
                        state_reg      <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        cmd_ready_reg <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign cmd_ready     = cmd_ready_reg;
    assign alu_a         = alu_a_reg;
    assign alu_b         = alu_b_reg;
    assign alu_binvert   = binvert_reg;
    assign alu_carryin   = binvert_reg;
    assign alu_operation = operation_reg;
    assign rsp_valid     = rsp_valid_reg;
    assign rsp_result    = rsp_result_reg;
    assign rsp_zero      = rsp_zero_reg;
    assign rsp_carry     = rsp_carry_reg;
    assign rsp_err       = rsp_err_reg;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Testbench for alu_cmd_driver: two instances (SETTLE_CYCLES 1 and 4), each wired to a
// behavioural combinational ALU, driven with directed and random commands and checked
// against an arithmetic reference model of the command semantics.
module tb_alu_cmd_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int settle [2] = '{1, 4};

    logic        reset_s         [2];
    logic        cmd_valid_s     [2];
    logic        cmd_ready_s     [2];
    logic [2:0]  cmd_op_s        [2];
    logic [31:0] cmd_a_s         [2];
    logic [31:0] cmd_b_s         [2];
    logic [31:0] alu_a_s         [2];
    logic [31:0] alu_b_s         [2];
    logic        alu_binvert_s   [2];
    logic        alu_carryin_s   [2];
    logic [1:0]  alu_operation_s [2];
    logic        rsp_valid_s     [2];
    logic        rsp_ready_s     [2];
    logic [31:0] rsp_result_s    [2];
    logic        rsp_zero_s      [2];
    logic        rsp_carry_s     [2];
    logic        rsp_err_s       [2];
    logic        rsp_ovf_s       [2];

    logic [31:0] last_a [2];
    logic [31:0] last_b [2];

    // Combinational ALU: {CarryOut, Result}
    function automatic logic [32:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic binv, input logic cin,
                                           input logic [1:0] opn);
        logic [31:0] bb;
        logic [32:0] sum;
        bb  = binv ? ~b : b;
        sum = {1'b0, a} + {1'b0, bb} + {32'd0, cin};
        case (opn)
            2'b00:   return {sum[32], a & bb};
            2'b01:   return {sum[32], a | bb};
            default: return sum;
        endcase
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            logic [32:0] alu_out;
            assign alu_out = alu_fn(alu_a_s[gi], alu_b_s[gi], alu_binvert_s[gi],
                                    alu_carryin_s[gi], alu_operation_s[gi]);
            alu_cmd_driver #(.WIDTH(32), .SETTLE_CYCLES((gi == 0) ? 1 : 4)) u_dut (
                .clk           (clk),
                .reset         (reset_s[gi]),
                .cmd_valid     (cmd_valid_s[gi]),
                .cmd_ready     (cmd_ready_s[gi]),
                .cmd_op        (cmd_op_s[gi]),
                .cmd_a         (cmd_a_s[gi]),
                .cmd_b         (cmd_b_s[gi]),
                .alu_a         (alu_a_s[gi]),
                .alu_b         (alu_b_s[gi]),
                .alu_binvert   (alu_binvert_s[gi]),
                .alu_carryin   (alu_carryin_s[gi]),
                .alu_operation (alu_operation_s[gi]),
                .alu_result    (alu_out[31:0]),
                .alu_carryout  (alu_out[32]),
                .rsp_valid     (rsp_valid_s[gi]),
                .rsp_ready     (rsp_ready_s[gi]),
                .rsp_result    (rsp_result_s[gi]),
                .rsp_zero      (rsp_zero_s[gi]),
                .rsp_carry     (rsp_carry_s[gi]),
`ifdef ALU_DRV_OVF_EN
                .rsp_err       (rsp_err_s[gi]),
                .rsp_ovf       (rsp_ovf_s[gi])
`else
                .rsp_err       (rsp_err_s[gi])
`endif
            );
`ifndef ALU_DRV_OVF_EN
            assign rsp_ovf_s[gi] = 1'b0;
`endif
        end
    endgenerate

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference semantics of a command, from plain arithmetic
    function automatic void ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] r, output logic c, output logic ov,
                                      output logic err);
        longint s;
        r = 0; c = 0; ov = 0; err = 0;
        case (op)
            3'b000: r = a & b;
            3'b001: r = a | b;
            3'b010: begin
                {c, r} = {1'b0, a} + {1'b0, b};
                s  = longint'($signed(a)) + longint'($signed(b));
                ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'b110: begin
                r  = a - b;
                c  = (a >= b);
                s  = longint'($signed(a)) - longint'($signed(b));
                ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'b111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: err = 1;
        endcase
    endfunction

    task automatic check_reset(input int i);
        check("rst_cmd_ready", cmd_ready_s[i], 1);
        check("rst_alu_a", alu_a_s[i], 0);
        check("rst_alu_b", alu_b_s[i], 0);
        check("rst_ctrl", {alu_binvert_s[i], alu_carryin_s[i], alu_operation_s[i]}, 0);
        check("rst_rsp_valid", rsp_valid_s[i], 0);
        check("rst_rsp", {rsp_result_s[i], rsp_zero_s[i], rsp_carry_s[i], rsp_err_s[i]}, 0);
`ifdef ALU_DRV_OVF_EN
        check("rst_ovf", rsp_ovf_s[i], 0);
`endif
        last_a[i] = 0;
        last_b[i] = 0;
    endtask

    task automatic run_cmd(input int i, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input int hold);
        logic [31:0] er;
        logic        ec, eo, ee, ebin;
        logic [1:0]  eopn;
        int          lat, exp_lat, wait_n;
        ref_model(op, a, b, er, ec, eo, ee);
        exp_lat = ee ? 1 : settle[i] + 1;
        ebin    = (op == 3'b110) || (op == 3'b111);
        eopn    = (op == 3'b000) ? 2'b00 : (op == 3'b001) ? 2'b01 : 2'b10;

        @(negedge clk);
        wait_n = 0;
        while (!cmd_ready_s[i] && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
        check("cmd_ready_idle", cmd_ready_s[i], 1);
        cmd_valid_s[i] = 1; cmd_op_s[i] = op; cmd_a_s[i] = a; cmd_b_s[i] = b;
        @(negedge clk);
        cmd_valid_s[i] = 0; cmd_a_s[i] = $urandom; cmd_b_s[i] = $urandom;
        check("cmd_ready_busy", cmd_ready_s[i], 0);
        if (!ee) begin
            last_a[i] = a;
            last_b[i] = b;
            check("alu_binvert", alu_binvert_s[i], ebin);
            check("alu_carryin", alu_carryin_s[i], ebin);
            check("alu_operation", alu_operation_s[i], eopn);
        end
        check("alu_a", alu_a_s[i], last_a[i]);
        check("alu_b", alu_b_s[i], last_b[i]);

        lat = 1;
        while (!rsp_valid_s[i] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, exp_lat);
        check("rsp_result", rsp_result_s[i], er);
        check("rsp_zero", rsp_zero_s[i], (er == 0));
        check("rsp_carry", rsp_carry_s[i], ec);
        check("rsp_err", rsp_err_s[i], ee);
`ifdef ALU_DRV_OVF_EN
        check("rsp_ovf", rsp_ovf_s[i], eo);
`endif
        $display("txn inst=%0d op=%b a=%h b=%h result=%h zero=%0d carry=%0d err=%0d ovf=%0d lat=%0d",
                 i, op, a, b, rsp_result_s[i], rsp_zero_s[i], rsp_carry_s[i], rsp_err_s[i],
                 rsp_ovf_s[i], lat);

        // Backpressure with a competing command that must be ignored
        for (int k = 0; k < hold; k++) begin
            cmd_valid_s[i] = 1; cmd_op_s[i] = 3'b010; cmd_a_s[i] = ~a; cmd_b_s[i] = ~b;
            @(negedge clk);
            check("bp_rsp_valid", rsp_valid_s[i], 1);
            check("bp_cmd_ready", cmd_ready_s[i], 0);
            check("bp_rsp_hold", {rsp_result_s[i], rsp_zero_s[i], rsp_carry_s[i], rsp_err_s[i]},
                  {er, (er == 0), ec, ee});
            check("bp_alu_a", alu_a_s[i], last_a[i]);
        end
        rsp_ready_s[i] = 1;
        @(negedge clk);
        rsp_ready_s[i] = 0;
        cmd_valid_s[i] = 0;
        check("hs_rsp_valid", rsp_valid_s[i], 0);
        check("hs_cmd_ready", cmd_ready_s[i], 1);
        check("hs_alu_a", alu_a_s[i], last_a[i]);
    endtask

    initial begin
        logic        any_valid;
        logic [2:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 2; i++) begin
            reset_s[i] = 1; cmd_valid_s[i] = 0; cmd_op_s[i] = 0;
            cmd_a_s[i] = 0; cmd_b_s[i] = 0; rsp_ready_s[i] = 0;
        end
        repeat (3) @(negedge clk);
        reset_s[0] = 0; reset_s[1] = 0;
        @(negedge clk);
        check_reset(0);
        check_reset(1);

        // Directed cases, SETTLE_CYCLES = 1
        run_cmd(0, 3'b000, 32'ha5a5a5a5, 32'h5a5a5a5a, 0);
        run_cmd(0, 3'b001, 32'ha5a5a5a5, 32'h5a5a5a5a, 0);
        run_cmd(0, 3'b010, 32'ha5a5a5a5, 32'h5a5a5a5a, 0);
        run_cmd(0, 3'b110, 32'ha5a5a5a5, 32'h5a5a5a5a, 0);
        run_cmd(0, 3'b111, 32'h80000000, 32'h00000001, 0);
        run_cmd(0, 3'b111, 32'h00000007, 32'h00000005, 0);
        run_cmd(0, 3'b010, 32'h12345678, 32'h11111111, 5);
        run_cmd(0, 3'b100, 32'hdeadbeef, 32'hcafef00d, 2);

        // Reset during EXEC, SETTLE_CYCLES = 4
        @(negedge clk);
        cmd_valid_s[1] = 1; cmd_op_s[1] = 3'b010; cmd_a_s[1] = 3; cmd_b_s[1] = 4;
        @(negedge clk);
        cmd_valid_s[1] = 0;
        @(negedge clk);
        reset_s[1] = 1;
        @(negedge clk);
        reset_s[1] = 0;
        check_reset(1);
        any_valid = 0;
        repeat (8) begin
            @(negedge clk);
            any_valid = any_valid | rsp_valid_s[1];
        end
        check("abandoned_no_rsp", any_valid, 0);
        run_cmd(1, 3'b010, 32'h00000001, 32'h00000001, 0);
        run_cmd(1, 3'b010, 32'h7fffffff, 32'h00000001, 1);
        run_cmd(1, 3'b110, 32'h80000000, 32'h00000001, 0);
        run_cmd(1, 3'b101, 32'h0, 32'h0, 0);

        // Random traffic on both instances
        for (int n = 0; n < 40; n++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 3))
                0: b = a;
                1: begin a = 32'h7fffffff; b = ($urandom_range(0, 1) != 0) ? 32'h80000000 : 32'h1; end
                default: ;
            endcase
            run_cmd(n % 2, op, a, b, $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_cmd_driver.md
Name: alu_cmd_driver

Overview:
Sequential initiator for the 32-bit combinational ALU (AND/OR/ADD/SUB datapath with Binvert/Carryin/Operation controls). It accepts operation commands over a valid/ready interface and decodes the opcode into ALU control lines. It registers the operands onto the ALU inputs, waits a programmable settle time, then captures Result/CarryOut. It returns result plus flags over a valid/ready response interface, and sits between the instruction/control path and the ALU.

Parameters:
WIDTH, 32, datapath width of operands and result.
SETTLE_CYCLES, 1, cycles spent in EXEC before capture (1..15); covers ripple-adder settle.

Ports:
clk  input  1  clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  driver can accept a command
cmd_op  input  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT; others illegal
cmd_a  input  WIDTH  operand A
cmd_b  input  WIDTH  operand B
alu_a  output  WIDTH  to ALU a
alu_b  output  WIDTH  to ALU b
alu_binvert  output  1  to ALU Binvert
alu_carryin  output  1  to ALU Carryin (equals alu_binvert)
alu_operation  output  2  to ALU Operation: 00 AND, 01 OR, 10 add/sub
alu_result  input  WIDTH  from ALU Result
alu_carryout  input  1  from ALU CarryOut
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_result  output  WIDTH  captured or derived result
rsp_zero  output  1  rsp_result == 0
rsp_carry  output  1  captured CarryOut; 0 for AND/OR/SLT/illegal
rsp_err  output  1  illegal opcode

Behaviour:
- Reset, applied at any state including mid-operation: state IDLE, settle counter 0, and all outputs 0 except cmd_ready=1. An in-flight operation is abandoned and produces no response.
- FSM states: IDLE, EXEC, DONE.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, a legal op registers alu_a=cmd_a and alu_b=cmd_b, sets controls, loads counter=SETTLE_CYCLES and goes to EXEC. An illegal op leaves the ALU outputs unchanged, loads rsp_result=0, rsp_err=1, rsp_zero=1, rsp_carry=0 and goes to DONE.
- Decode: AND {binvert=0,op=00}; OR {0,01}; ADD {0,10}; SUB and SLT {1,10}.
- EXEC: cmd_ready=0. The counter decrements each cycle. The edge at which the counter equals 1 captures alu_result/alu_carryout into the rsp regs and goes to DONE.
- Latency: rsp_valid is high exactly SETTLE_CYCLES+1 cycles after the accept edge for legal ops, and 1 cycle after for illegal ops.
- SLT: rsp_result = {WIDTH-1 zeros, alu_result[WIDTH-1] ^ ovf}, where ovf = (alu_a[MSB]!=alu_b[MSB]) && (alu_result[MSB]!=alu_a[MSB]). rsp_carry=0.
- rsp_zero is computed from the final rsp_result.
- DONE: rsp_valid=1, cmd_ready=0. All rsp_* outputs are held stable until rsp_valid&&rsp_ready. At that edge rsp_valid drops and the FSM returns to IDLE. No command is accepted in the same cycle.
- alu_* outputs hold their last values after capture and change only on the next legal accept.
- cmd_valid while not in IDLE is ignored; there is no queueing.
- Arithmetic is modulo 2^WIDTH. For SUB, rsp_carry=1 means no borrow.

Optional Feature:
ALU_DRV_OVF_EN: when defined, adds output port rsp_ovf (1 bit). It carries signed overflow for ADD/SUB, using the ovf formula with alu_b replaced by ~alu_b for ADD. It is 0 for other ops, 0 on reset, and held like the other rsp_* outputs. When undefined, the port and its logic are absent and behaviour is otherwise identical.

Test Plan:
1. AND, a=a5a5a5a5, b=5a5a5a5a, SETTLE_CYCLES=1 -> alu_operation=00, rsp_result=00000000, zero=1, carry=0, rsp_valid 2 cycles after accept.
2. OR, then ADD, same operands -> OR: ffffffff, zero=0. ADD: ffffffff, carry=0, binvert=0.
3. SUB a5a5a5a5-5a5a5a5a -> binvert=1, carryin=1, op=10, result 4b4b4b4b, carry=1. SLT a=80000000,b=00000001 -> 1. SLT a=7,b=5 -> 0.
4. Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_* stable, cmd_ready=0, a second cmd_valid is ignored. Release -> IDLE, next cmd accepted.
5. Illegal op 100 -> rsp_valid 1 cycle after accept, err=1, result 0, zero=1, alu_* unchanged.
6. SETTLE_CYCLES=4: assert reset during EXEC -> all outputs reset, no rsp_valid. A fresh ADD 1+1 gives 2 at 5 cycles latency. With ALU_DRV_OVF_EN, ADD 7fffffff+1 -> ovf=1.
